// File: rtl/easyaxi_run_ctrl.sv
// Run sequencer for multi-channel EASYAXI regressions: settle, enable, collect done, drain, repeat.
// Optional RUN-duration tracking on lat_max is built only when EASYAXI_RUN_CTRL_LAT_EN is defined.
module easyaxi_run_ctrl #(
  parameter int NUM_CH      = 2,
  parameter int NUM_RUNS    = 4,
  parameter int RST_WAIT    = 5,
  parameter int DRAIN_CYC   = 100,
  parameter int TIMEOUT_CYC = 10000,
  parameter int CNT_W       = 16,
  parameter int RUN_W       = $clog2(NUM_RUNS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              clr,
  input  logic [NUM_CH-1:0] done,
  output logic [NUM_CH-1:0] enable,
  output logic              busy,
  output logic              finish,
  output logic              pass,
  output logic              timeout,
  output logic [RUN_W-1:0]  run_cnt,
  output logic [CNT_W-1:0]  lat_max
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_RST,
    S_RUN,
    S_DRAIN,
    S_FINISH,
    S_TIMEOUT
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   wdog_q, wdog_d;
  logic [NUM_CH-1:0]  en_q, en_d;
  logic [NUM_CH-1:0]  seen_q, seen_d;
  logic [RUN_W-1:0]   run_q, run_d;
  logic               fin_q, fin_d;
  logic               pass_q, pass_d;
  logic               tmo_q, tmo_d;
  logic               all_done;

  // A channel counts as done if it was seen earlier in this run or reports done right now.
  assign all_done = &(seen_q | done);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wdog_d  = wdog_q;
    en_d    = en_q;
    seen_d  = seen_q;
    run_d   = run_q;
    fin_d   = fin_q;
    pass_d  = pass_q;
    tmo_d   = tmo_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_WAIT_RST;
          cnt_d   = '0;
        end
      end
      S_WAIT_RST: begin
        if (cnt_q == CNT_W'(RST_WAIT - 1)) begin
          state_d = S_RUN;
          en_d    = '1;
          wdog_d  = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RUN: begin
        seen_d = seen_q | (done & en_q);
        en_d   = en_q & ~done;
        wdog_d = wdog_q + CNT_W'(1);
        if (all_done) begin
          state_d = S_DRAIN;
          en_d    = '0;
          cnt_d   = '0;
        end else if (wdog_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          state_d = S_TIMEOUT;
          en_d    = '0;
          tmo_d   = 1'b1;
          fin_d   = 1'b1;
        end
      end
      S_DRAIN: begin
        en_d = '0;
        if (cnt_q == CNT_W'(DRAIN_CYC - 1)) begin
          run_d  = run_q + RUN_W'(1);
          seen_d = '0;
          if (run_q == RUN_W'(NUM_RUNS - 1)) begin
            state_d = S_FINISH;
            fin_d   = 1'b1;
            pass_d  = 1'b1;
          end else begin
            state_d = S_WAIT_RST;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_FINISH, S_TIMEOUT: begin
      end
      default: state_d = S_IDLE;
    endcase

    // clr overrides every transition above, including a start on the same edge.
    if (clr) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      wdog_d  = '0;
      en_d    = '0;
      seen_d  = '0;
      run_d   = '0;
      fin_d   = 1'b0;
      pass_d  = 1'b0;
      tmo_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wdog_q  <= '0;
      en_q    <= '0;
      seen_q  <= '0;
      run_q   <= '0;
      fin_q   <= 1'b0;
      pass_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wdog_q  <= wdog_d;
      en_q    <= en_d;
      seen_q  <= seen_d;
      run_q   <= run_d;
      fin_q   <= fin_d;
      pass_q  <= pass_d;
      tmo_q   <= tmo_d;
    end
  end

  assign enable  = en_q;
  assign busy    = (state_q == S_WAIT_RST) || (state_q == S_RUN) || (state_q == S_DRAIN);
  assign finish  = fin_q;
  assign pass    = pass_q;
  assign timeout = tmo_q;
  assign run_cnt = run_q;

`ifdef EASYAXI_RUN_CTRL_LAT_EN
  logic [CNT_W-1:0] lat_q, lat_d;
  logic [CNT_W-1:0] run_dur;

  // Duration of the RUN phase ending on this edge, counted in cycles.
  assign run_dur = wdog_q + CNT_W'(1);

  always_comb begin
    lat_d = lat_q;
    if (clr) begin
      lat_d = '0;
    end else if ((state_q == S_RUN) && all_done && (run_dur > lat_q)) begin
      lat_d = run_dur;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_q <= '0;
    end else begin
      lat_q <= lat_d;
    end
  end

  assign lat_max = lat_q;
`else
  assign lat_max = '0;
`endif

endmodule

// File: tb/tb_easyaxi_run_ctrl.sv
// Scoreboard bench for easyaxi_run_ctrl: a run-level model predicts every output change,
// a monitor compares each observed change in order. Honours EASYAXI_RUN_CTRL_LAT_EN.
module tb_easyaxi_run_ctrl;
  localparam int NCH   = 3;
  localparam int NRUNS = 3;
  localparam int RWAIT = 5;
  localparam int DRAIN = 8;
  localparam int TOUT  = 40;
  localparam int CW    = 16;
  localparam int RW    = $clog2(NRUNS + 1);
  localparam int NEVER = 1000000;

  localparam int K_FULL  = 0;
  localparam int K_BOUND = 1;
  localparam int K_TOUT  = 2;
  localparam int K_CLR   = 3;
  localparam int K_RST   = 4;

  typedef struct packed {
    logic [NCH-1:0] en;
    logic [RW-1:0]  rc;
    logic           fin;
    logic           pas;
    logic           tmo;
    logic           bsy;
    logic [CW-1:0]  lat;
  } snap_t;

  typedef struct {
    int    cyc;
    snap_t s;
  } ev_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic           clr;
  logic [NCH-1:0] done = '0;
  logic [NCH-1:0] enable;
  logic           busy, finish, pass, timeout;
  logic [RW-1:0]  run_cnt;
  logic [CW-1:0]  lat_max;

  int cyc = 0;
  int chk_cnt = 0;
  int pass_cnt = 0;

  ev_t            exp_q[$];
  ev_t            plan[$];
  snap_t          m;
  snap_t          prev;
  bit [NCH-1:0]   dplan [int];
  bit [NCH-1:0]   forbid [int];
  int             dtab [NRUNS][NCH];

  easyaxi_run_ctrl #(
    .NUM_CH(NCH), .NUM_RUNS(NRUNS), .RST_WAIT(RWAIT), .DRAIN_CYC(DRAIN),
    .TIMEOUT_CYC(TOUT), .CNT_W(CW), .RUN_W(RW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clr(clr), .done(done),
    .enable(enable), .busy(busy), .finish(finish), .pass(pass),
    .timeout(timeout), .run_cnt(run_cnt), .lat_max(lat_max)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic snap_t cur_snap();
    return {enable, run_cnt, finish, pass, timeout, busy, lat_max};
  endfunction

  function automatic string fmt(snap_t s);
    return $sformatf("en=%b run_cnt=%0d fin=%b pass=%b tmo=%b busy=%b lat=%0d",
                     s.en, s.rc, s.fin, s.pas, s.tmo, s.bsy, s.lat);
  endfunction

  function automatic void add(int c);
    ev_t e;
    e.cyc = c;
    e.s   = m;
    plan.push_back(e);
  endfunction

  function automatic void mark(int k, int i, bit is_pulse);
    bit [NCH-1:0] v;
    if (is_pulse) begin
      v = dplan.exists(k) ? dplan[k] : '0;
      v[i] = 1'b1;
      dplan[k] = v;
    end else begin
      v = forbid.exists(k) ? forbid[k] : '0;
      v[i] = 1'b1;
      forbid[k] = v;
    end
  endfunction

  // Run-level model: enable rises RWAIT edges after a run begins, each channel drops on its
  // own done edge, the run ends when every channel is done or after TOUT RUN cycles.
  task automatic build_plan(input int n, output int end_c);
    int e, t, rend;
    logic [NCH-1:0] en, en_new;
    plan.delete();
    end_c = n;
    m.bsy = 1'b1;
    add(n);
    e = n + RWAIT;
    for (int r = 0; r < NRUNS; r++) begin
      en = '1;
      m.en = en;
      add(e);
      for (t = 1; t <= TOUT; t++) begin
        en_new = en;
        for (int i = 0; i < NCH; i++) begin
          if (t <= dtab[r][i]) mark(e + t, i, 1'b0);
          if (dtab[r][i] == t) begin
            en_new[i] = 1'b0;
            mark(e + t, i, 1'b1);
          end
        end
        if (en_new == '0) break;
        if (t == TOUT) begin
          m.en = '0; m.tmo = 1'b1; m.fin = 1'b1; m.bsy = 1'b0;
          add(e + t);
          end_c = e + t;
          return;
        end
        if (en_new != en) begin
          m.en = en_new;
          add(e + t);
        end
        en = en_new;
      end
      m.en = '0;
`ifdef EASYAXI_RUN_CTRL_LAT_EN
      if (CW'(t) > m.lat) m.lat = CW'(t);
`endif
      add(e + t);
      rend = e + t + DRAIN;
      m.rc = m.rc + RW'(1);
      if (r == NRUNS - 1) begin
        m.fin = 1'b1; m.pas = 1'b1; m.bsy = 1'b0;
      end
      add(rend);
      end_c = rend;
      e = rend + RWAIT;
    end
  endtask

  // Done driver: scheduled pulses plus random done wherever the DUT must ignore it.
  always @(negedge clk) begin
    bit [NCH-1:0] s, f, nz;
    int k;
    k = cyc + 1;
    s = dplan.exists(k) ? dplan[k] : '0;
    f = forbid.exists(k) ? forbid[k] : '0;
    for (int i = 0; i < NCH; i++) nz[i] = ($urandom_range(3) == 0);
    done = s | (nz & ~f);
  end

  // Monitor: every change of the output snapshot must be the next expected event.
  always @(negedge clk) begin
    snap_t cur;
    ev_t ev;
    cur = cur_snap();
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      ev = exp_q.pop_front();
      chk_cnt++;
      $display("FAIL missed_event cyc=%0d: never saw %s (now %s)", ev.cyc, fmt(ev.s), fmt(cur));
    end
    if (cur != prev) begin
      chk_cnt++;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        ev = exp_q.pop_front();
        if (cur == ev.s) begin
          pass_cnt++;
          $display("event cyc=%0d %s ok", cyc, fmt(cur));
        end else begin
          $display("FAIL event cyc=%0d: got %s, expected %s", cyc, fmt(cur), fmt(ev.s));
        end
      end else begin
        $display("FAIL unexpected_change cyc=%0d: got %s, was %s", cyc, fmt(cur), fmt(prev));
      end
    end
    prev = cur;
  end

  function automatic void push_exp(int c, snap_t s);
    ev_t e;
    e.cyc = c;
    e.s   = s;
    exp_q.push_back(e);
  endfunction

  task automatic check(input string name, input snap_t got, input snap_t want);
    chk_cnt++;
    if (got == want) begin
      pass_cnt++;
      $display("check %s cyc=%0d %s ok", name, cyc, fmt(got));
    end else begin
      $display("FAIL %s cyc=%0d: got %s, expected %s", name, cyc, fmt(got), fmt(want));
    end
  endtask

  // Advance to the negedge where cyc==target; optionally poke start while the DUT is busy.
  task automatic wait_to(input int target, input bit poke);
    do begin
      @(negedge clk);
      if (cyc < target) start = poke && ($urandom_range(7) == 0);
    end while (cyc < target);
    start = 1'b0;
  endtask

  task automatic do_clr();
    snap_t z;
    z = '0;
    clr = 1'b1;
    start = 1'b1;
    if (m != '0) push_exp(cyc + 1, '0);
    m = '0;
    @(negedge clk);
    clr = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("clr_start_stays_idle", cur_snap(), z);
  endtask

  task automatic scenario(input int kind);
    int n, end_c, cut, rr;
    snap_t z;
    z = '0;
    for (int r = 0; r < NRUNS; r++)
      for (int i = 0; i < NCH; i++)
        dtab[r][i] = (kind == K_BOUND && r == NRUNS - 1) ? int'($urandom_range(TOUT, 1))
                                                          : int'($urandom_range(12, 1));
    if (kind == K_BOUND) dtab[NRUNS-1][$urandom_range(NCH-1)] = TOUT;
    if (kind == K_TOUT) begin
      rr = int'($urandom_range(NRUNS-1));
      dtab[rr][$urandom_range(NCH-1)] = NEVER;
    end
    dplan.delete();
    forbid.delete();
    @(negedge clk);
    n = cyc + 1;
    start = 1'b1;
    build_plan(n, end_c);
    cut = (kind >= K_CLR) ? int'($urandom_range(end_c - 1, n + 1)) : end_c + 1;
    foreach (plan[k]) if (plan[k].cyc < cut) exp_q.push_back(plan[k]);
    if (kind == K_CLR) begin
      wait_to(cut - 1, 1'b1);
      do_clr();
    end else if (kind == K_RST) begin
      wait_to(cut - 1, 1'b1);
      @(posedge clk);
      #2;
      push_exp(cyc, '0);
      m = '0;
      rst_n = 1'b0;
      #1;
      check("async_reset_mid_run", cur_snap(), z);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
    end else begin
      wait_to(end_c + 6, 1'b1);
      do_clr();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL global_watchdog: simulation exceeded time limit at cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    snap_t z;
    z = '0;
    m = '0;
    prev = '0;
    rst_n = 1'b0;
    start = 1'b0;
    clr = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", cur_snap(), z);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    for (int it = 0; it < 2; it++) begin
      scenario(K_FULL);
      scenario(K_BOUND);
      scenario(K_TOUT);
      scenario(K_CLR);
      scenario(K_RST);
    end
    repeat (5) @(negedge clk);
    chk_cnt++;
    if (exp_q.size() == 0) begin
      pass_cnt++;
      $display("check scoreboard_drained ok");
    end else begin
      $display("FAIL scoreboard_drained: %0d events outstanding, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
